// File: rtl/stbus_slot_rx.sv
// ST-BUS receive deframer: locks onto the frame pulse, extracts one selected
// 8-bit timeslot per frame and queues it to the host through a small FIFO.
module stbus_slot_rx #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int NSLOT = 32
) (
  input  logic       c4,
  input  logic       rst_n,
  input  logic       f0,
  input  logic       clk_en_rx,
  input  logic       din,
  input  logic [4:0] slot_sel,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       locked,
  output logic       frame_err,
  output logic       overflow
);

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    SYNC = 2'b01,
    LOCK = 2'b10
  } state_t;

  localparam logic [8:0] FRAME_LEN_C = 9'(NSLOT * 8);

  state_t      state_r;
  logic        f0_prev_r;
  logic        first_r;
  logic [7:0]  bit_cnt_r;
  logic [7:0]  shreg_r;
  logic [8:0]  strb_cnt_r;
  logic [4:0]  sel_r;
  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [7:0]  dout_r;
  logic        dout_valid_r;
  logic        locked_r;
  logic        frame_err_r;
  logic        overflow_r;

  logic        fs_s;
  logic [7:0]  cur_idx_s;
  logic [7:0]  byte_s;
  logic        push_s;
  logic        pop_s;
  logic        full_s;
  logic        wr_en_s;
  logic        drop_s;
  logic [AW:0] wr_next_s;
  logic [AW:0] rd_next_s;
  logic [7:0]  head_s;

  // Frame-start detect, bit index of the current strobe, push/pop decode and next FIFO head
  always_comb begin
    fs_s = f0_prev_r & ~f0;
    // first_r: an fs was seen without a strobe, so the next strobe is bit 0
    if (fs_s || first_r) begin
      cur_idx_s = 8'd0;
    end else begin
      cur_idx_s = bit_cnt_r + 8'd1;
    end
    byte_s    = {shreg_r[6:0], din};
    push_s    = (state_r == LOCK) && clk_en_rx && (cur_idx_s[2:0] == 3'd7) &&
                (cur_idx_s[7:3] == sel_r);
    pop_s     = dout_valid_r & dout_ready;
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    wr_en_s   = push_s & (~full_s | pop_s);
    drop_s    = push_s & full_s & ~pop_s;
    wr_next_s = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
    rd_next_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
    // A byte written this cycle into an otherwise empty FIFO becomes the head directly
    if (rd_next_s == wr_ptr_r) begin
      head_s = byte_s;
    end else begin
      head_s = mem_r[rd_next_s[AW-1:0]];
    end
  end

  // Bit counter and serial shift register
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      f0_prev_r <= 1'b1;
      first_r   <= 1'b1;
      bit_cnt_r <= 8'd0;
      shreg_r   <= 8'h00;
    end else begin
      f0_prev_r <= f0;
      if (fs_s || clk_en_rx) begin
        bit_cnt_r <= clk_en_rx ? cur_idx_s : 8'd0;
        first_r   <= ~clk_en_rx;
      end
      if (clk_en_rx) begin
        shreg_r <= byte_s;
      end
    end
  end

  // Frame alignment state machine with slot latch and strobe counter
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      strb_cnt_r  <= 9'd0;
      sel_r       <= 5'd0;
      locked_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if (fs_s) begin
        sel_r      <= slot_sel;
        strb_cnt_r <= clk_en_rx ? 9'd1 : 9'd0;
        case (state_r)
          HUNT: begin
            state_r  <= SYNC;
            locked_r <= 1'b0;
          end
          SYNC: begin
            if (strb_cnt_r == FRAME_LEN_C) begin
              state_r  <= LOCK;
              locked_r <= 1'b1;
            end else begin
              state_r  <= SYNC;
              locked_r <= 1'b0;
            end
          end
          LOCK: begin
            if (strb_cnt_r != FRAME_LEN_C) begin
              state_r     <= HUNT;
              locked_r    <= 1'b0;
              frame_err_r <= 1'b1;
            end
          end
          default: begin
            state_r  <= HUNT;
            locked_r <= 1'b0;
          end
        endcase
      end else if (clk_en_rx) begin
        // Saturate so a long fs-less stretch never aliases back to a full frame
        if (strb_cnt_r != 9'h1FF) begin
          strb_cnt_r <= strb_cnt_r + 9'd1;
        end
        if ((state_r == LOCK) && (strb_cnt_r == FRAME_LEN_C)) begin
          state_r     <= HUNT;
          locked_r    <= 1'b0;
          frame_err_r <= 1'b1;
        end
      end
    end
  end

  // Output FIFO with registered head and valid
  always_ff @(posedge c4 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      dout_r       <= 8'h00;
      dout_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= byte_s;
      end
      wr_ptr_r     <= wr_next_s;
      rd_ptr_r     <= rd_next_s;
      dout_valid_r <= (rd_next_s != wr_next_s);
      if (rd_next_s != wr_next_s) begin
        dout_r <= head_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign locked     = locked_r;
  assign frame_err  = frame_err_r;
  assign overflow   = overflow_r;

endmodule
